// File: rtl/char_text_buffer.sv
// Character text buffer: a RAM of character codes with a registered read port,
// and a command FSM that writes single chars and BCD numbers and clears rows or the whole screen.
module char_text_buffer #(
  parameter int COLS_W = 5,
  parameter int ROWS_W = 5,
  parameter int CODE_W = 7,
  parameter int DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ROWS_W+COLS_W-1:0] char_yx,
  output logic [CODE_W-1:0]        char_code,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [ROWS_W+COLS_W-1:0] cmd_yx,
  input  logic [4*DIGITS-1:0]      cmd_data,
  output logic                     cmd_done,
  output logic [1:0]               dbg_state
);

  localparam int AW      = ROWS_W + COLS_W;
  localparam int DEPTH   = 1 << AW;
  localparam int CW      = (AW > 4) ? AW : 4;
  localparam int SW      = COLS_W + CW + 1;
  localparam int COL_MAX = (1 << COLS_W) - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NUM  = 2'd1,
    CLR  = 2'd2
  } state_t;

  logic [CODE_W-1:0]   mem [DEPTH];
  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [ROWS_W-1:0]   row_q;
  logic [COLS_W-1:0]   col_q;
  logic [4*DIGITS-1:0] data_q;
  logic                clr_all_q;
  logic                auto_q;
  logic                done_q;
  logic [CODE_W-1:0]   char_code_q;

  logic                we;
  logic [AW-1:0]       wa;
  logic [CODE_W-1:0]   wd;
  logic [3:0]          nib;
  logic [SW-1:0]       col_sum;
  logic                num_last;
  logic                clr_last;

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE and the cmd_* inputs are sampled on that edge.
  assign cmd_ready = (state_q == IDLE);
  assign cmd_done  = done_q;
  assign char_code = char_code_q;
  assign dbg_state = state_q;

  assign num_last = (cnt_q == CW'(DIGITS - 1));
  assign clr_last = clr_all_q ? (cnt_q[AW-1:0] == '1) : (cnt_q[COLS_W-1:0] == '1);

  always_comb begin
    we      = 1'b0;
    wa      = '0;
    wd      = '0;
    nib     = data_q[4*DIGITS-1 -: 4];
    col_sum = SW'(col_q) + SW'(cnt_q);
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_op == 2'b00) begin
          we = 1'b1;
          wa = cmd_yx;
          wd = cmd_data[CODE_W-1:0];
        end
      end
      NUM: begin
        // Digits past the last column are dropped rather than wrapped.
        if (col_sum <= SW'(COL_MAX)) begin
          we = 1'b1;
          wa = {row_q, col_sum[COLS_W-1:0]};
          wd = (nib > 4'd9) ? CODE_W'(63) : CODE_W'(48) + CODE_W'(nib);
        end
      end
      CLR: begin
        we = 1'b1;
        wa = clr_all_q ? cnt_q[AW-1:0] : {row_q, cnt_q[COLS_W-1:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Read-first: the read samples mem before the same-edge write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) char_code_q <= '0;
    else        char_code_q <= mem[char_yx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLR;
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      data_q    <= '0;
      clr_all_q <= 1'b1;
      auto_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            row_q  <= cmd_yx[AW-1:COLS_W];
            col_q  <= cmd_yx[COLS_W-1:0];
            data_q <= cmd_data;
            cnt_q  <= '0;
            case (cmd_op)
              2'b00: done_q <= 1'b1;
              2'b01: state_q <= NUM;
              2'b10: begin
                state_q   <= CLR;
                clr_all_q <= 1'b1;
              end
              default: begin
                state_q   <= CLR;
                clr_all_q <= 1'b0;
              end
            endcase
          end
        end
        NUM: begin
          data_q <= data_q << 4;
          cnt_q  <= cnt_q + 1'b1;
          if (num_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        CLR: begin
          cnt_q <= cnt_q + 1'b1;
          if (clr_last) begin
            // The post-reset clear finishes silently.
            state_q <= IDLE;
            done_q  <= !auto_q;
            auto_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_text_buffer.sv
// Directed bench for char_text_buffer: reset clear, char/number writes, row clear,
// read-first behaviour and reset during a clear-all.
module tb_char_text_buffer;

  logic        clk;
  logic        rst_n;
  logic [9:0]  char_yx;
  logic [6:0]  char_code;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [9:0]  cmd_yx;
  logic [15:0] cmd_data;
  logic        cmd_done;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  char_text_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .char_yx   (char_yx),
    .char_code (char_code),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_yx    (cmd_yx),
    .cmd_data  (cmd_data),
    .cmd_done  (cmd_done),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [6:0] fill_code(input int r, input int c);
    return 7'(32 + ((r * 5 + c) % 90));
  endfunction

  task automatic read_cell(input logic [9:0] a, output logic [6:0] v);
    @(negedge clk);
    char_yx = a;
    @(negedge clk);
    v = char_code;
  endtask

  // Issue one command and count the cycles cmd_ready stays low afterwards.
  // With hold set, cmd_valid stays high during busy with a char write to 0x025 presented.
  task automatic do_cmd(input logic [1:0] op, input logic [9:0] yx, input logic [15:0] data,
                        input bit hold, output int busy);
    @(negedge clk);
    done_cnt  = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_yx    = yx;
    cmd_data  = data;
    @(negedge clk);
    if (hold) begin
      cmd_op   = 2'b00;
      cmd_yx   = 10'h025;
      cmd_data = 16'h0055;
    end else begin
      cmd_valid = 1'b0;
    end
    busy = 0;
    while (!cmd_ready && busy < 2000) begin
      busy++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_clear(output int busy);
    busy = 0;
    do begin
      @(posedge clk);
      #1;
      busy++;
    end while (!cmd_ready && busy < 2000);
  endtask

  initial begin
    int         busy;
    int         errs;
    logic [6:0] v;

    rst_n     = 1'b1;
    char_yx   = 10'h041;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_yx    = '0;
    cmd_data  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_char_code", char_code, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_cmd_done", cmd_done, 0);

    done_cnt = 0;
    rst_n = 1'b1;
    wait_clear(busy);
    check("init_clear_cycles", busy, 1024);
    @(negedge clk);
    check("init_ready", cmd_ready, 1);
    errs = 0;
    for (int a = 0; a < 1024; a++) begin
      read_cell(10'(a), v);
      if (v !== 7'd0) errs++;
    end
    check("init_nonzero_cells", errs, 0);
    check("init_no_done", done_cnt, 0);
    check("idle_state", dbg_state, 0);

    do_cmd(2'b00, 10'h041, 16'd89, 1'b0, busy);
    check("wr_busy", busy, 0);
    check("wr_done", done_cnt, 1);
    read_cell(10'h041, v);
    check("wr_read_041", v, 89);

    @(negedge clk);
    char_yx   = 10'h041;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_yx    = 10'h041;
    cmd_data  = 16'd33;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("rd_first_old", char_code, 89);
    @(negedge clk);
    check("rd_after_wr", char_code, 33);

    do_cmd(2'b01, 10'h08C, 16'h1234, 1'b0, busy);
    check("num_busy", busy, 4);
    check("num_done", done_cnt, 1);
    for (int i = 0; i < 4; i++) begin
      read_cell(10'h08C + 10'(i), v);
      check($sformatf("num_cell_%0d", i), v, 49 + i);
    end
    read_cell(10'h090, v);
    check("num_next_cell", v, 0);

    do_cmd(2'b01, 10'h01E, 16'h9A57, 1'b0, busy);
    check("edge_busy", busy, 4);
    check("edge_done", done_cnt, 1);
    read_cell(10'h01E, v);
    check("edge_01E", v, 57);
    read_cell(10'h01F, v);
    check("edge_01F", v, 63);
    errs = 0;
    for (int c = 0; c < 32; c++) begin
      read_cell({5'd1, 5'(c)}, v);
      if (v !== 7'd0) errs++;
    end
    read_cell(10'h000, v);
    if (v !== 7'd0) errs++;
    read_cell(10'h001, v);
    if (v !== 7'd0) errs++;
    check("edge_no_wrap", errs, 0);

    for (int r = 1; r <= 3; r++)
      for (int c = 0; c < 32; c++)
        do_cmd(2'b00, {5'(r), 5'(c)}, {9'd0, fill_code(r, c)}, 1'b0, busy);
    do_cmd(2'b11, 10'h05A, 16'h0000, 1'b1, busy);
    check("clr_row_busy", busy, 32);
    check("clr_row_done", done_cnt, 1);
    check("clr_row_ready", cmd_ready, 1);
    for (int r = 1; r <= 3; r++) begin
      errs = 0;
      for (int c = 0; c < 32; c++) begin
        read_cell({5'(r), 5'(c)}, v);
        if (v !== ((r == 2) ? 7'd0 : fill_code(r, c))) errs++;
      end
      check($sformatf("clr_row_r%0d", r), errs, 0);
    end

    do_cmd(2'b00, 10'h3F0, 16'd77, 1'b0, busy);
    @(negedge clk);
    char_yx   = 10'h3F0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (511) @(negedge clk);
    check("clr_all_mid_read", char_code, 77);
    check("clr_all_mid_busy", cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_char_code", char_code, 0);
    check("abort_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    done_cnt = 0;
    rst_n = 1'b1;
    wait_clear(busy);
    check("abort_clear_cycles", busy, 1024);
    @(negedge clk);
    @(negedge clk);
    check("abort_ready_after", cmd_ready, 1);
    check("abort_no_done", done_cnt, 0);
    read_cell(10'h3F0, v);
    check("abort_cell_cleared", v, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/char_text_buffer.md
CHAR_TEXT_BUFFER -- requirements
Module: char_text_buffer

Interface
REQ-001 Parameter COLS_W, default 5, column address width; the buffer has 2^COLS_W columns.
REQ-002 Parameter ROWS_W, default 5, row address width; the buffer has 2^ROWS_W rows.
REQ-003 Parameter CODE_W, default 7, character code width.
REQ-004 Parameter DIGITS, default 4, number of BCD digits written by one number command (1..8).
REQ-005 Port clk, input, 1, single clock; all logic rises on posedge clk.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port char_yx, input, ROWS_W+COLS_W, display read address {row, col}.
REQ-008 Port char_code, output, CODE_W, registered character code at char_yx.
REQ-009 Port cmd_valid, input, 1, command request.
REQ-010 Port cmd_ready, output, 1, high when the block accepts a command.
REQ-011 Port cmd_op, input, 2, command: 00 write char, 01 write BCD number, 10 clear all, 11 clear row.
REQ-012 Port cmd_yx, input, ROWS_W+COLS_W, target {row, col}.
REQ-013 Port cmd_data, input, 4*DIGITS, char code in [CODE_W-1:0] for op 00; BCD digits, MSD in top nibble, for op 01.
REQ-014 Port cmd_done, output, 1, one-cycle pulse when any accepted command finishes its last write.

Function
REQ-015 Storage SHALL be a 2^(ROWS_W+COLS_W) x CODE_W RAM with one read port and one write port.
REQ-016 char_code SHALL equal mem[char_yx] sampled one cycle earlier, giving 1-cycle latency; reads continue during every command.
REQ-017 A read and write to the same address in the same cycle SHALL return the old data (read-first).
REQ-018 A command SHALL be accepted only in the cycle where cmd_valid and cmd_ready are both high; cmd_* SHALL be captured in that cycle.
REQ-019 The FSM SHALL have states IDLE, NUM, CLR. cmd_ready SHALL be high only in IDLE.
REQ-020 Op 00 SHALL write cmd_data[CODE_W-1:0] to cmd_yx in the acceptance cycle, stay in IDLE, and pulse cmd_done in the next cycle.
REQ-021 Op 01 SHALL go to NUM and write DIGITS cells, one per cycle, MSD first, at columns col, col+1, ... of the captured row.
REQ-022 Each digit d<=9 SHALL be written as 48+d; a digit >9 SHALL be written as 63 ('?').
REQ-023 In NUM, digits whose column would exceed 2^COLS_W-1 SHALL be dropped, not wrapped; the command still takes DIGITS cycles.
REQ-024 Op 10 SHALL go to CLR and write 0 to every address, ascending from 0, one per cycle, taking 2^(ROWS_W+COLS_W) cycles.
REQ-025 Op 11 SHALL go to CLR and write 0 to columns 0..2^COLS_W-1 of the captured row, taking 2^COLS_W cycles; cmd_yx col is ignored.
REQ-026 On the last write of NUM or CLR, the FSM SHALL return to IDLE in the next cycle, and cmd_done SHALL pulse in that same cycle.
REQ-027 In NUM and CLR, cmd_valid SHALL be ignored; commands are not queued.
REQ-028 Walk counters SHALL be sized to the operation so that no terminal count wraps before completion.

Reset
REQ-029 While rst_n is low: char_code=0, cmd_ready=0, cmd_done=0.
REQ-030 After rst_n deasserts, the block SHALL start an automatic clear-all (CLR, 2^(ROWS_W+COLS_W) cycles) with no cmd_done pulse; cmd_ready SHALL rise when it finishes.
REQ-031 Asserting rst_n at any time, including mid-command, SHALL abort the command; RAM contents are then undefined until the automatic clear completes.

Verification
REQ-032 Default params, release reset -> cmd_ready low for exactly 1024 cycles, then high; reading every address returns 0; no cmd_done pulse.
REQ-033 Op 00, yx=0x041, data=89 -> one cycle after the write, driving char_yx=0x041 gives char_code=89 on the next cycle; cmd_done pulses once.
REQ-034 Op 01, yx=0x08C, data=0x1234 -> cells 0x08C..0x08F = 49,50,51,52; cmd_ready low for 4 cycles; cmd_done pulses once.
REQ-035 Op 01, yx=0x01E, data=0x9A57 -> 0x01E=57, 0x01F=63; row 1 is unchanged; 4 busy cycles.
REQ-036 Op 11 on row 2 after filling rows 1-3 -> row 2 is all 0, rows 1 and 3 are intact, 32 busy cycles; cmd_valid held during busy is not accepted.
REQ-037 Assert rst_n halfway through op 10 -> char_code=0 at once; after release there are 1024 clear cycles and then cmd_ready=1.
